// File: rtl/sisc_seq_ctrl_if.sv
// Strobe/flag bundle between the SISC sequencer and its datapath.
// The sequencer side is the master; the datapath side is the slave.
interface sisc_seq_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       opcode;
    logic [3:0]       mm;
    logic [3:0]       stat;
    logic             pc_rst;
    logic             pc_write;
    logic             pc_sel;
    logic             br_sel;
    logic             ir_load;
    logic             rb_sel;
    logic [1:0]       alu_op;
    logic             stat_en;
    logic             dm_we;
    logic             wb_sel;
    logic             rf_we;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, mm, stat,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel, alu_op,
               stat_en, dm_we, wb_sel, rf_we, halted, instr_cnt
    );

    modport slave (
        output opcode, mm, stat,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel, alu_op,
               stat_en, dm_we, wb_sel, rf_we, halted, instr_cnt
    );
endinterface

// File: rtl/sisc_seq_ctrl.sv
// Multi-cycle SISC sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with branch
// resolution against statreg flags, HLT handling and a retired-instruction counter.
module sisc_seq_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [3:0]  HLT_OP = 4'hF
) (
    input  logic           clk,
    input  logic           rst_f,
    sisc_seq_ctrl_if.master ctrl
);
    localparam logic [3:0] S_START0 = 4'd0;
    localparam logic [3:0] S_START1 = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;

    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_LOD = 4'd2;
    localparam logic [3:0] OP_STR = 4'd3;
    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;

    logic [3:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    // Only the immediate flag of mm matters once DECODE has resolved branches.
    logic             mm_q, mm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic             taken;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mm_d    = mm_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_START0: state_d = S_START1;
            S_START1: state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d    = ctrl.opcode;
                mm_d    = ctrl.mm[3];
                state_d = (ctrl.opcode == HLT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC:   state_d = S_MEM;
            S_MEM:    state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_START0;
            op_q    <= '0;
            mm_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mm_q    <= mm_d;
            cnt_q   <= cnt_d;
        end
    end

    // Branch resolution is the only path from live inputs to outputs.
    always_comb begin
        hit   = |(ctrl.mm & ctrl.stat);
        taken = 1'b0;
        if (ctrl.opcode != HLT_OP) begin
            case (ctrl.opcode)
                OP_BRA, OP_BRR: taken = hit;
                OP_BNE, OP_BNR: taken = !hit;
                default:        taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        ctrl.pc_rst   = 1'b0;
        ctrl.pc_write = 1'b0;
        ctrl.pc_sel   = 1'b0;
        ctrl.br_sel   = 1'b0;
        ctrl.ir_load  = 1'b0;
        ctrl.rb_sel   = 1'b0;
        ctrl.alu_op   = 2'b11;
        ctrl.stat_en  = 1'b0;
        ctrl.dm_we    = 1'b0;
        ctrl.wb_sel   = 1'b0;
        ctrl.rf_we    = 1'b0;
        ctrl.halted   = 1'b0;
        case (state_q)
            S_START0: ctrl.pc_rst = 1'b1;
            S_FETCH: begin
                ctrl.ir_load  = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_DECODE: begin
                ctrl.pc_write = taken;
                ctrl.pc_sel   = taken;
                ctrl.br_sel   = taken && (ctrl.opcode == OP_BRR || ctrl.opcode == OP_BNR);
            end
            S_EXEC: begin
                if (op_q == OP_ALU) begin
                    ctrl.alu_op  = mm_q ? 2'b01 : 2'b00;
                    ctrl.stat_en = 1'b1;
                end else if (op_q == OP_LOD || op_q == OP_STR) begin
                    ctrl.alu_op = 2'b10;
                end
            end
            S_MEM: begin
                if (op_q == OP_STR) begin
                    ctrl.dm_we  = 1'b1;
                    ctrl.rb_sel = 1'b1;
                end else if (op_q == OP_LOD) begin
                    ctrl.wb_sel = 1'b1;
                end
            end
            S_WB: begin
                if (op_q == OP_ALU) begin
                    ctrl.rf_we = 1'b1;
                end else if (op_q == OP_LOD) begin
                    ctrl.rf_we  = 1'b1;
                    ctrl.wb_sel = 1'b1;
                end
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

    assign ctrl.instr_cnt = cnt_q;
endmodule

// File: tb/tb_sisc_seq_ctrl.sv
// Randomized scoreboard bench for sisc_seq_ctrl: per-instruction expected strobe
// sequences are queued by the stimulus and consumed cycle by cycle by a monitor.
module tb_sisc_seq_ctrl;
    localparam int unsigned CW  = 4;
    localparam logic [3:0]  HLT = 4'hF;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       ir_load;
        logic       rb_sel;
        logic [1:0] alu_op;
        logic       stat_en;
        logic       dm_we;
        logic       wb_sel;
        logic       rf_we;
        logic       halted;
    } strb_t;

    typedef struct packed {
        strb_t       s;
        logic [CW-1:0] cnt;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_f;
    always #5 clk = ~clk;

    sisc_seq_ctrl_if #(.CNT_W(CW)) bus ();

    sisc_seq_ctrl #(.CNT_W(CW), .HLT_OP(HLT)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .ctrl  (bus)
    );

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_cnt  = 0;
    exp_t  mon_e;
    strb_t mon_a;

    function automatic strb_t idle();
        strb_t s;
        s = '0;
        s.alu_op = 2'b11;
        return s;
    endfunction

    task automatic push(input strb_t s, input logic [7:0] tag);
        exp_t e;
        e.s   = s;
        e.cnt = CW'(m_cnt);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.opcode = 4'($urandom);
        bus.mm     = 4'($urandom);
        bus.stat   = 4'($urandom);
    endtask

    task automatic do_reset(input int n);
        strb_t s;
        rst_f = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            rand_inputs();
            s = idle();
            s.pc_rst = 1'b1;
            push(s, 8'd0);
        end
        rst_f = 1'b1;
        next_cycle();
        rand_inputs();
        push(idle(), 8'd1);
    endtask

    // abort_at: 5 asserts rst_f during MEM; any other value runs to completion.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm,
                             input logic [3:0] st, input int abort_at);
        strb_t s;
        bit    hit;
        bit    taken;

        next_cycle();
        rand_inputs();
        s = idle();
        s.ir_load  = 1'b1;
        s.pc_write = 1'b1;
        push(s, 8'd2);

        next_cycle();
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = st;
        hit   = (mm & st) != 4'd0;
        taken = (op == 4'd4 || op == 4'd5) ? hit :
                (op == 4'd6 || op == 4'd7) ? !hit : 1'b0;
        s = idle();
        if (taken) begin
            s.pc_write = 1'b1;
            s.pc_sel   = 1'b1;
            s.br_sel   = (op == 4'd5 || op == 4'd7);
        end
        push(s, 8'd3);

        if (op == HLT) begin
            for (int i = 0; i < 20; i++) begin
                next_cycle();
                rand_inputs();
                s = idle();
                s.halted = 1'b1;
                push(s, 8'd7);
            end
            return;
        end

        next_cycle();
        rand_inputs();
        s = idle();
        if (op == 4'd1) begin
            s.alu_op  = mm[3] ? 2'b01 : 2'b00;
            s.stat_en = 1'b1;
        end else if (op == 4'd2 || op == 4'd3) begin
            s.alu_op = 2'b10;
        end
        push(s, 8'd4);

        next_cycle();
        rand_inputs();
        s = idle();
        if (op == 4'd3) begin
            s.dm_we  = 1'b1;
            s.rb_sel = 1'b1;
        end else if (op == 4'd2) begin
            s.wb_sel = 1'b1;
        end
        push(s, 8'd5);
        if (abort_at == 5) begin
            rst_f = 1'b0;
            return;
        end

        next_cycle();
        rand_inputs();
        s = idle();
        if (op == 4'd1) begin
            s.rf_we = 1'b1;
        end else if (op == 4'd2) begin
            s.rf_we  = 1'b1;
            s.wb_sel = 1'b1;
        end
        push(s, 8'd6);
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.pc_rst   = bus.pc_rst;
            mon_a.pc_write = bus.pc_write;
            mon_a.pc_sel   = bus.pc_sel;
            mon_a.br_sel   = bus.br_sel;
            mon_a.ir_load  = bus.ir_load;
            mon_a.rb_sel   = bus.rb_sel;
            mon_a.alu_op   = bus.alu_op;
            mon_a.stat_en  = bus.stat_en;
            mon_a.dm_we    = bus.dm_we;
            mon_a.wb_sel   = bus.wb_sel;
            mon_a.rf_we    = bus.rf_we;
            mon_a.halted   = bus.halted;
            checks++;
            if (mon_a !== mon_e.s || bus.instr_cnt !== mon_e.cnt) begin
                errors++;
                $display("FAIL phase%0d t=%0t strobes act=%b exp=%b cnt act=%0d exp=%0d",
                         mon_e.tag, $time, mon_a, mon_e.s, bus.instr_cnt, mon_e.cnt);
            end
        end
    end

    initial begin
        rst_f      = 1'b0;
        bus.opcode = 4'd0;
        bus.mm     = 4'd0;
        bus.stat   = 4'd0;

        do_reset(3);
        run_instr(4'd1, 4'b1000, 4'($urandom), 0);
        run_instr(4'd1, 4'b0111, 4'($urandom), 0);
        run_instr(4'd4, 4'b0001, 4'b0001, 0);
        run_instr(4'd4, 4'b0001, 4'b0000, 0);
        run_instr(4'd5, 4'b0110, 4'b0100, 0);
        run_instr(4'd6, 4'b0010, 4'b0010, 0);
        run_instr(4'd7, 4'b0010, 4'b0000, 0);
        run_instr(4'd3, 4'($urandom), 4'($urandom), 0);
        run_instr(4'd2, 4'($urandom), 4'($urandom), 0);

        for (int i = 0; i < 60; i++)
            run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 0);

        do_reset(2);
        for (int i = 0; i < 17; i++)
            run_instr(4'd1, 4'($urandom), 4'($urandom), 0);
        run_instr(4'd0, 4'($urandom), 4'($urandom), 0);

        run_instr(4'd3, 4'($urandom), 4'($urandom), 5);
        do_reset(2);
        run_instr(4'd0, 4'($urandom), 4'($urandom), 0);
        run_instr(HLT, 4'($urandom), 4'($urandom), 0);
        do_reset(3);
        run_instr(4'd1, 4'b1000, 4'($urandom), 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
